bus_control_sequencer: RTL and testbench
========================================

Name: bus_control_sequencer

Overview:
- Fetch/decode/execute microsequencer for the 8-bit FPGAComputer bus.
- Each microstep it selects exactly one bus source module (drives its OE) and asserts the load strobe of zero or more destination modules (drives their WE).
- It also pulses PC increment, ALU subtract and flag latch.
- It replaces manual SEL/OE/WE/GO control once a program is in RAM; in programming mode it idles.

Parameters:
- DATA_W, 8, bus and IR width.
- SEL_W, 4, module select width.
- NUM_MOD, 16, number of selectable modules (LOAD width).
- OPC_W, 4, opcode width; IR[7:4] = opcode, IR[3:0] = operand.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  synchronous, active-low reset.
- EN  in  1  run enable; 0 freezes the sequencer.
- HLT  in  1  halt request.
- PRGM  in  1  programming mode; sequencer idles.
- IR  in  DATA_W  instruction register contents.
- CARRY  in  1  latched ALU carry flag.
- ZERO  in  1  latched ALU zero flag.
- BUS_SRC  out  SEL_W  module ID driving the bus.
- BUS_OE  out  1  BUS_SRC is valid and its OE is asserted.
- LOAD  out  NUM_MOD  per-module WE, bit i = module ID i.
- PC_INC  out  1  PC count enable.
- ALU_SUB  out  1  ALU subtract select.
- FLAG_WE  out  1  latch CARRY/ZERO.
- TSTATE  out  3  current microstep (0-4; 7 = HALT).
- HALTED  out  1  in HALT state.
- ON  out  1  actively sequencing: EN=1, PRGM=0, not halted, RESET high.

Behaviour:
- State register: T0..T4, HALT. Outputs are combinational from the registered state, IR, CARRY and ZERO.
- Strobe gating:
  - All strobes (BUS_OE, LOAD, PC_INC, ALU_SUB, FLAG_WE) are 0 whenever RESET=0, PRGM=1 or EN=0.
  - BUS_SRC = 0 whenever BUS_OE=0.
- Reset (RESET=0 at an edge): state <= T0. While RESET is low: TSTATE=0, HALTED=0, ON=0, all strobes 0.
- Priority: RESET > PRGM > EN=0 > HLT > normal.
- PRGM=1: state <= T0 on the next edge (aborts any instruction, exits HALT).
- EN=0: state holds; the same step re-executes when EN returns.
- Module IDs: PC=0, MAR=1, RAM=2, IR=3, A=4, B=5, ALU=6, OUT=7. IDs 8-15 are reserved and never driven.
- Fetch (all opcodes):
  - T0: PC->MAR.
  - T1: RAM->IR, PC_INC=1.
- Execute from T2. In the per-opcode steps, "IR" as a source means the low-nibble operand: module IR drives IR[3:0] onto the bus.
  - NOP: T2 idle.
  - LDA: T2 IR->MAR; T3 RAM->A.
  - ADD: T2 IR->MAR; T3 RAM->B; T4 ALU->A, FLAG_WE=1.
  - SUB: same as ADD; ALU_SUB=1 in T4.
  - STA: T2 IR->MAR; T3 A->RAM.
  - LDI: T2 IR->A.
  - JMP: T2 IR->PC.
  - JC: T2 IR->PC if CARRY=1, else idle.
  - JZ: T2 IR->PC if ZERO=1, else idle.
  - OUT: T2 A->OUT.
  - HLT: T2 idle, next state HALT.
- Opcode encoding: NOP=0 LDA=1 ADD=2 SUB=3 STA=4 LDI=5 JMP=6 JC=7 JZ=8 OUT=E HLT=F. Undefined opcodes 9-D execute as NOP.
- Instruction length: after an instruction's last step the next state is T0, with no padding. Cycle counts:
  - NOP/LDI/JMP/JC/JZ/OUT: 3
  - LDA/STA: 4
  - ADD/SUB: 5
- HLT input: sampled only at the last step of an instruction. If HLT=1 there, next state = HALT instead of T0. The in-flight instruction always completes.
- HALT: all strobes 0, HALTED=1, TSTATE=7. Exits only via RESET or PRGM.
- Arithmetic: none internal. The operand is 4 bits, so jump/memory targets are limited to 0-15.
- Invariants:
  - At most one source per cycle.
  - LOAD never includes the bit of BUS_SRC.

Decomposition:
- Shared package: module ID constants, opcode constants, TSTATE encodings (T0-T4, HALT=7).
- One natural sub-module: bus_ctrl_ucode_decode, combinational (state, opcode, flags) -> strobe word plus last-step flag. The top level holds the state register and the EN/PRGM/HLT/RESET logic.

Test Plan:
- RESET=0 for 2 cycles, then RESET=1, EN=1, IR=8'h10 -> TSTATE 0,1,2,3,0. BUS_SRC 0,2,3,2. LOAD bits {1},{3},{1},{4}. PC_INC=1 only in T1.
- IR=8'h27 (ADD 7) -> 5-cycle instruction. In T4: BUS_SRC=6, LOAD[4]=1, FLAG_WE=1, ALU_SUB=0. For IR=8'h37 the same, with ALU_SUB=1 in T4.
- IR=8'h7A with CARRY=0 -> T2 has BUS_OE=0, LOAD=0. With CARRY=1 -> T2 BUS_SRC=3, LOAD[0]=1. Repeat for JZ (8'h8A) with ZERO.
- EN dropped during T3 of LDA for 3 cycles -> TSTATE stays 3, all strobes 0. On EN=1, T3 RAM->A executes once.
- HLT=1 asserted in T2 of ADD -> T3, T4 complete, then HALTED=1, TSTATE=7, ON=0. Holds for 10 cycles. PRGM=1 for 1 cycle -> TSTATE=0, HALTED=0.
- IR=8'hF0 -> halt after T2. RESET=0 mid-halt -> TSTATE=0, all strobes 0 during reset. Fetch resumes at T0 after release.

Source files
------------

// File: rtl/bus_control_sequencer_pkg.sv
// bus_control_sequencer_pkg
//   Shared constants for the FPGAComputer bus microsequencer: bus module IDs,
//   opcode encodings, microstep (TSTATE) encodings and the microcode word
//   exchanged between the decoder and the sequencer top level.
package bus_control_sequencer_pkg;

  localparam int DATA_W  = 8;   // bus and IR width
  localparam int SEL_W   = 4;   // module select width
  localparam int NUM_MOD = 16;  // number of selectable modules
  localparam int OPC_W   = 4;   // opcode width, IR[7:4]

  // Bus module IDs; 8-15 are reserved and never driven.
  localparam logic [SEL_W-1:0] MOD_PC  = 4'd0;
  localparam logic [SEL_W-1:0] MOD_MAR = 4'd1;
  localparam logic [SEL_W-1:0] MOD_RAM = 4'd2;
  localparam logic [SEL_W-1:0] MOD_IR  = 4'd3;
  localparam logic [SEL_W-1:0] MOD_A   = 4'd4;
  localparam logic [SEL_W-1:0] MOD_B   = 4'd5;
  localparam logic [SEL_W-1:0] MOD_ALU = 4'd6;
  localparam logic [SEL_W-1:0] MOD_OUT = 4'd7;

  // Opcodes; 9-D are undefined and run as NOP.
  localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
  localparam logic [OPC_W-1:0] OP_LDA = 4'h1;
  localparam logic [OPC_W-1:0] OP_ADD = 4'h2;
  localparam logic [OPC_W-1:0] OP_SUB = 4'h3;
  localparam logic [OPC_W-1:0] OP_STA = 4'h4;
  localparam logic [OPC_W-1:0] OP_LDI = 4'h5;
  localparam logic [OPC_W-1:0] OP_JMP = 4'h6;
  localparam logic [OPC_W-1:0] OP_JC  = 4'h7;
  localparam logic [OPC_W-1:0] OP_JZ  = 4'h8;
  localparam logic [OPC_W-1:0] OP_OUT = 4'hE;
  localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

  // Microstep encodings, visible on TSTATE.
  typedef enum logic [2:0] {
    ST_T0   = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_T4   = 3'd4,
    ST_HALT = 3'd7
  } tstate_e;

  // One microstep worth of control. 'last' marks the final step of an
  // instruction; 'halt' asks for HALT instead of T0 after that step.
  typedef struct packed {
    logic               oe;
    logic [SEL_W-1:0]   src;
    logic [NUM_MOD-1:0] load;
    logic               pc_inc;
    logic               alu_sub;
    logic               flag_we;
    logic               last;
    logic               halt;
  } ucode_t;

  // One-hot WE bit for a module ID.
  function automatic logic [NUM_MOD-1:0] mod_bit(input logic [SEL_W-1:0] id);
    return {{(NUM_MOD-1){1'b0}}, 1'b1} << id;
  endfunction

endpackage

// File: rtl/bus_control_sequencer_ucode_decode.sv
// bus_ctrl_ucode_decode
//   Combinational microcode ROM: (microstep, opcode, flags) -> one control word.
//   Ports:
//     i_state  : current microstep
//     i_opcode : IR[7:4]
//     i_carry  : latched ALU carry (JC condition)
//     i_zero   : latched ALU zero  (JZ condition)
//     o_uc     : bus source/OE, per-module loads, PC_INC/ALU_SUB/FLAG_WE,
//                last-step and halt-after flags
//   No gating happens here; the top level masks strobes for reset/PRGM/EN.
module bus_ctrl_ucode_decode
  import bus_control_sequencer_pkg::*;
(
  input  tstate_e          i_state,
  input  logic [OPC_W-1:0] i_opcode,
  input  logic             i_carry,
  input  logic             i_zero,
  output ucode_t           o_uc
);

  always_comb begin
    o_uc = '0;
    case (i_state)
      ST_T0: begin
        o_uc.oe   = 1'b1;
        o_uc.src  = MOD_PC;
        o_uc.load = mod_bit(MOD_MAR);
      end
      ST_T1: begin
        o_uc.oe     = 1'b1;
        o_uc.src    = MOD_RAM;
        o_uc.load   = mod_bit(MOD_IR);
        o_uc.pc_inc = 1'b1;
      end
      ST_T2: begin
        case (i_opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            o_uc.oe   = 1'b1;
            o_uc.src  = MOD_IR;
            o_uc.load = mod_bit(MOD_MAR);
          end
          OP_LDI: begin
            o_uc.oe   = 1'b1;
            o_uc.src  = MOD_IR;
            o_uc.load = mod_bit(MOD_A);
            o_uc.last = 1'b1;
          end
          OP_JMP: begin
            o_uc.oe   = 1'b1;
            o_uc.src  = MOD_IR;
            o_uc.load = mod_bit(MOD_PC);
            o_uc.last = 1'b1;
          end
          // Conditional jumps always take three cycles; untaken is idle.
          OP_JC, OP_JZ: begin
            if ((i_opcode == OP_JC) ? i_carry : i_zero) begin
              o_uc.oe   = 1'b1;
              o_uc.src  = MOD_IR;
              o_uc.load = mod_bit(MOD_PC);
            end
            o_uc.last = 1'b1;
          end
          OP_OUT: begin
            o_uc.oe   = 1'b1;
            o_uc.src  = MOD_A;
            o_uc.load = mod_bit(MOD_OUT);
            o_uc.last = 1'b1;
          end
          OP_HLT: begin
            o_uc.last = 1'b1;
            o_uc.halt = 1'b1;
          end
          default: o_uc.last = 1'b1;  // NOP and undefined opcodes
        endcase
      end
      ST_T3: begin
        case (i_opcode)
          OP_LDA: begin
            o_uc.oe   = 1'b1;
            o_uc.src  = MOD_RAM;
            o_uc.load = mod_bit(MOD_A);
            o_uc.last = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            o_uc.oe   = 1'b1;
            o_uc.src  = MOD_RAM;
            o_uc.load = mod_bit(MOD_B);
          end
          OP_STA: begin
            o_uc.oe   = 1'b1;
            o_uc.src  = MOD_A;
            o_uc.load = mod_bit(MOD_RAM);
            o_uc.last = 1'b1;
          end
          default: o_uc.last = 1'b1;  // unreachable; recover to T0
        endcase
      end
      ST_T4: begin
        if (i_opcode == OP_ADD || i_opcode == OP_SUB) begin
          o_uc.oe      = 1'b1;
          o_uc.src     = MOD_ALU;
          o_uc.load    = mod_bit(MOD_A);
          o_uc.flag_we = 1'b1;
          o_uc.alu_sub = (i_opcode == OP_SUB);
        end
        o_uc.last = 1'b1;
      end
      default: o_uc = '0;  // HALT: everything quiet
    endcase
  end

endmodule

// File: rtl/bus_control_sequencer.sv
// bus_control_sequencer
//   Fetch/decode/execute microsequencer for the 8-bit FPGAComputer bus.
//   Holds the microstep register and the RESET/PRGM/EN/HLT priority logic;
//   the per-step control word comes from bus_ctrl_ucode_decode.
//   Ports:
//     CLK, RESET (sync, active low), EN (run enable), HLT (halt request),
//     PRGM (programming mode), IR (instruction), CARRY/ZERO (ALU flags)
//     BUS_SRC/BUS_OE : bus source ID and its output enable
//     LOAD           : per-module WE, bit i = module ID i
//     PC_INC, ALU_SUB, FLAG_WE : auxiliary strobes
//     TSTATE (0-4, 7=HALT), HALTED, ON : sequencer status
//   Outputs are combinational from the registered microstep, IR and flags.
module bus_control_sequencer
  import bus_control_sequencer_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  input  logic               EN,
  input  logic               HLT,
  input  logic               PRGM,
  input  logic [DATA_W-1:0]  IR,
  input  logic               CARRY,
  input  logic               ZERO,
  output logic [SEL_W-1:0]   BUS_SRC,
  output logic               BUS_OE,
  output logic [NUM_MOD-1:0] LOAD,
  output logic               PC_INC,
  output logic               ALU_SUB,
  output logic               FLAG_WE,
  output logic [2:0]         TSTATE,
  output logic               HALTED,
  output logic               ON
);

  tstate_e r_state;
  ucode_t  w_uc;
  logic    w_run;
  logic    w_unused_operand;

  // The operand nibble goes straight to the bus through module IR.
  assign w_unused_operand = ^IR[DATA_W-OPC_W-1:0];

  bus_ctrl_ucode_decode u_decode (
    .i_state  (r_state),
    .i_opcode (IR[DATA_W-1:DATA_W-OPC_W]),
    .i_carry  (CARRY),
    .i_zero   (ZERO),
    .o_uc     (w_uc)
  );

  // Priority: RESET > PRGM > EN=0 (hold) > HALT (sticky) > normal stepping.
  // HLT is only looked at on an instruction's last step, so the in-flight
  // instruction always completes.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state <= ST_T0;
    end else if (PRGM) begin
      r_state <= ST_T0;
    end else if (EN && r_state != ST_HALT) begin
      if (w_uc.last)
        r_state <= (HLT || w_uc.halt) ? ST_HALT : ST_T0;
      else
        r_state <= tstate_e'(r_state + 3'd1);
    end
  end

  assign w_run   = RESET && !PRGM && EN;

  assign BUS_OE  = w_run && w_uc.oe;
  assign BUS_SRC = BUS_OE ? w_uc.src : '0;
  assign LOAD    = w_run ? w_uc.load : '0;
  assign PC_INC  = w_run && w_uc.pc_inc;
  assign ALU_SUB = w_run && w_uc.alu_sub;
  assign FLAG_WE = w_run && w_uc.flag_we;

  assign TSTATE  = RESET ? r_state : ST_T0;
  assign HALTED  = RESET && (r_state == ST_HALT);
  assign ON      = w_run && (r_state != ST_HALT);

endmodule

// File: tb/tb_bus_control_sequencer.sv
// tb_bus_control_sequencer
//   Directed-vector bench for bus_control_sequencer. Inputs change 2 ns after
//   a rising edge; outputs are sampled 1 ns later, well away from the edge.
module tb_bus_control_sequencer;

  logic        CLK = 1'b0;
  logic        RESET, EN, HLT, PRGM, CARRY, ZERO;
  logic [7:0]  IR;
  logic [3:0]  BUS_SRC;
  logic        BUS_OE;
  logic [15:0] LOAD;
  logic        PC_INC, ALU_SUB, FLAG_WE;
  logic [2:0]  TSTATE;
  logic        HALTED, ON;

  int n_checks = 0;
  int n_pass   = 0;

  // clock / reset block
  always #5 CLK = ~CLK;

  bus_control_sequencer dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .EN      (EN),
    .HLT     (HLT),
    .PRGM    (PRGM),
    .IR      (IR),
    .CARRY   (CARRY),
    .ZERO    (ZERO),
    .BUS_SRC (BUS_SRC),
    .BUS_OE  (BUS_OE),
    .LOAD    (LOAD),
    .PC_INC  (PC_INC),
    .ALU_SUB (ALU_SUB),
    .FLAG_WE (FLAG_WE),
    .TSTATE  (TSTATE),
    .HALTED  (HALTED),
    .ON      (ON)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  // Checks every strobe for the current microstep against hand values.
  task automatic expect_step(input string tag, input int ts, input bit oe,
                             input int src, input int load, input bit pc,
                             input bit sub, input bit fwe);
    #1;
    check({tag, "_tstate"},  32'(TSTATE),  32'(ts));
    check({tag, "_oe"},      32'(BUS_OE),  32'(oe));
    check({tag, "_src"},     32'(BUS_SRC), 32'(src));
    check({tag, "_load"},    32'(LOAD),    32'(load));
    check({tag, "_pcinc"},   32'(PC_INC),  32'(pc));
    check({tag, "_sub"},     32'(ALU_SUB), 32'(sub));
    check({tag, "_flagwe"},  32'(FLAG_WE), 32'(fwe));
    check({tag, "_selfld"},  32'(BUS_OE & LOAD[BUS_SRC]), 32'd0);
  endtask

  // Runs T0 and T1 of the instruction in IR; leaves the sequencer in T2.
  task automatic fetch(input string tag);
    expect_step({tag, "_t0"}, 0, 1, 0, 'h0002, 0, 0, 0);
    tick();
    expect_step({tag, "_t1"}, 1, 1, 2, 'h0008, 1, 0, 0);
    tick();
  endtask

  initial begin
    RESET = 1'b0; EN = 1'b1; HLT = 1'b0; PRGM = 1'b0;
    CARRY = 1'b0; ZERO = 1'b0; IR = 8'h10;
    tick(); tick();
    expect_step("rst", 0, 0, 0, 0, 0, 0, 0);
    check("rst_on", 32'(ON), 0);
    check("rst_halted", 32'(HALTED), 0);

    // LDA 0
    RESET = 1'b1;
    fetch("lda");
    check("lda_on", 32'(ON), 1);
    expect_step("lda_t2", 2, 1, 3, 'h0002, 0, 0, 0);
    tick();
    expect_step("lda_t3", 3, 1, 2, 'h0010, 0, 0, 0);
    tick();

    // ADD 7
    IR = 8'h27;
    fetch("add");
    expect_step("add_t2", 2, 1, 3, 'h0002, 0, 0, 0);
    tick();
    expect_step("add_t3", 3, 1, 2, 'h0020, 0, 0, 0);
    tick();
    expect_step("add_t4", 4, 1, 6, 'h0010, 0, 0, 1);
    tick();

    // SUB 7
    IR = 8'h37;
    fetch("sub");
    expect_step("sub_t2", 2, 1, 3, 'h0002, 0, 0, 0);
    tick();
    expect_step("sub_t3", 3, 1, 2, 'h0020, 0, 0, 0);
    tick();
    expect_step("sub_t4", 4, 1, 6, 'h0010, 0, 1, 1);
    tick();

    // JC not taken / taken
    IR = 8'h7A; CARRY = 1'b0;
    fetch("jcn");
    expect_step("jcn_t2", 2, 0, 0, 0, 0, 0, 0);
    tick();
    CARRY = 1'b1;
    fetch("jct");
    expect_step("jct_t2", 2, 1, 3, 'h0001, 0, 0, 0);
    tick();
    CARRY = 1'b0;

    // JZ not taken / taken
    IR = 8'h8A; ZERO = 1'b0;
    fetch("jzn");
    expect_step("jzn_t2", 2, 0, 0, 0, 0, 0, 0);
    tick();
    ZERO = 1'b1;
    fetch("jzt");
    expect_step("jzt_t2", 2, 1, 3, 'h0001, 0, 0, 0);
    tick();
    ZERO = 1'b0;

    // EN dropped in T3 of LDA
    IR = 8'h10;
    fetch("enh");
    expect_step("enh_t2", 2, 1, 3, 'h0002, 0, 0, 0);
    tick();
    EN = 1'b0;
    expect_step("enh_off", 3, 0, 0, 0, 0, 0, 0);
    check("enh_on", 32'(ON), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_step("enh_hold", 3, 0, 0, 0, 0, 0, 0);
    end
    EN = 1'b1;
    expect_step("enh_t3", 3, 1, 2, 'h0010, 0, 0, 0);
    tick();

    // HLT request raised during T2 of ADD
    IR = 8'h27;
    fetch("hlt");
    expect_step("hlt_t2", 2, 1, 3, 'h0002, 0, 0, 0);
    HLT = 1'b1;
    tick();
    expect_step("hlt_t3", 3, 1, 2, 'h0020, 0, 0, 0);
    tick();
    expect_step("hlt_t4", 4, 1, 6, 'h0010, 0, 0, 1);
    tick();
    expect_step("hlt_halt", 7, 0, 0, 0, 0, 0, 0);
    check("hlt_halted", 32'(HALTED), 1);
    check("hlt_on", 32'(ON), 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      #1;
      check("hlt_hold", 32'(TSTATE), 7);
    end
    PRGM = 1'b1;
    HLT = 1'b0;
    tick();
    #1;
    check("prgm_tstate", 32'(TSTATE), 0);
    check("prgm_halted", 32'(HALTED), 0);
    check("prgm_oe", 32'(BUS_OE), 0);
    check("prgm_on", 32'(ON), 0);
    PRGM = 1'b0;

    // HLT opcode, then reset out of HALT
    IR = 8'hF0;
    fetch("hop");
    expect_step("hop_t2", 2, 0, 0, 0, 0, 0, 0);
    tick();
    #1;
    check("hop_halt", 32'(TSTATE), 7);
    check("hop_halted", 32'(HALTED), 1);
    RESET = 1'b0;
    expect_step("hop_rst", 0, 0, 0, 0, 0, 0, 0);
    check("hop_rst_halted", 32'(HALTED), 0);
    tick();
    expect_step("hop_rst2", 0, 0, 0, 0, 0, 0, 0);
    IR = 8'h10;
    RESET = 1'b1;
    fetch("resume");
    expect_step("resume_t2", 2, 1, 3, 'h0002, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
